// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, reset PC, the NOP
// instruction word, and a helper that word-aligns an address.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rv32i fetch: one outstanding imem read, 3 cycles/instr on zero-wait memory.
// Holds {instr, instr_pc} until instr_ready; no new request while holding.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;

  // Low target bits are forced to zero by word_align; they carry no state.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem_gnt) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          state_d       = HOLD;
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d       = REQ;
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
        end
      end
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; a granted-but-unreturned read
    // must still be drained in DROP so its late rvalid is not mistaken.
    if (redirect) begin
      pc_d          = word_align(redirect_pc);
      instr_d       = NOP_INSTR;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_gnt ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task walks the FSM cycle by cycle and
// checks outputs 1 time unit after the rising edge against hand-computed values.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr, NOP); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", instr_pc); end
  endtask

  // Zero-wait memory: first instr_valid after the 3rd edge following release.
  task automatic test_zero_wait();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_idle_req got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL zw_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL zw_wait got req=%b vld=%b want 0/0", imem_req, instr_valid); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h0) begin errors++; $display("FAIL zw_hold got vld=%b instr=%h pc=%h want 1/00500093/0", instr_valid, instr, instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL zw_next got vld=%b instr=%h req=%b addr=%h want 0/%h/1/4", instr_valid, instr, imem_req, imem_addr, NOP); end
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL stall_req[%0d] got req=%b addr=%h want 1/4", i, imem_req, imem_addr); end
    end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_wait got vld=%b req=%b want 0/0", instr_valid, imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h4) begin errors++; $display("FAIL stall_hold got vld=%b instr=%h pc=%h want 1/00a00113/4", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A0_0113 || instr_pc !== 32'h4 || imem_req !== 1'b0 || imem_addr !== 32'h8) begin
        errors++; $display("FAIL hold[%0d] got vld=%b instr=%h pc=%h req=%b addr=%h want 1/00a00113/4/0/8", i, instr_valid, instr, instr_pc, imem_req, imem_addr);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL hold_release got vld=%b req=%b addr=%h want 0/1/8", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop got req=%b addr=%h vld=%b want 0/100/0", imem_req, imem_addr, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdw_discard got vld=%b instr=%h req=%b addr=%h want 0/%h/1/100", instr_valid, instr, imem_req, imem_addr, NOP); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0537;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0537 || instr_pc !== 32'h100) begin errors++; $display("FAIL rdw_target got vld=%b instr=%h pc=%h want 1/00000537/100", instr_valid, instr, instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    redirect = 1'b0; imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL rdr_req got req=%b addr=%h vld=%b instr=%h want 1/200/0/%h", imem_req, imem_addr, instr_valid, instr, NOP); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h0010_0073 || instr_pc !== 32'h200) begin errors++; $display("FAIL rdr_target got vld=%b instr=%h pc=%h want 1/00100073/200", instr_valid, instr, instr_pc); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    // Redirect in REQ without gnt just moves the address.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h0000_006F || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_hold got pc=%h instr=%h addr=%h want fffffffc/0000006f/0", instr_pc, instr, imem_addr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL pre_rst_wait got addr=%h req=%b want 4/0", imem_addr, imem_req); end
    // Asynchronous reset while WAIT: no clock edge between assert and check.
    rst = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
      errors++; $display("FAIL rst_wait got addr=%h req=%b vld=%b instr=%h pc=%h want 0/0/0/%h/0", imem_addr, imem_req, instr_valid, instr, instr_pc, NOP);
    end
    tick(); tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL late_rvalid_idle got req=%b vld=%b addr=%h want 1/0/0", imem_req, instr_valid, imem_addr); end
    tick();
    imem_rvalid = 1'b0;
    checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("FAIL late_rvalid_req got req=%b vld=%b instr=%h want 1/0/%h", imem_req, instr_valid, instr, NOP); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL pre_rst_hold got vld=%b addr=%h want 1/4", instr_valid, imem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== NOP || imem_addr !== 32'h0 || instr_pc !== 32'h0) begin
      errors++; $display("FAIL rst_hold got vld=%b instr=%h addr=%h pc=%h want 0/%h/0/0", instr_valid, instr, imem_addr, instr_pc, NOP);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_gnt_stall();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
